// File: rtl/context_stats_update_if.sv
// Sample-in / statistics-out bus between context quantisation, the stats engine and the Golomb coder.
interface context_stats_update_if #(
   parameter int unsigned CTX_W    = 9,
   parameter int unsigned ERR_W    = 9,
   parameter int unsigned A_LENGTH = 16,
   parameter int unsigned B_LENGTH = 8,
   parameter int unsigned N_LENGTH = 7
);
   logic                       in_valid;
   logic                       in_ready;
   logic [CTX_W-1:0]           in_ctx;
   logic signed [ERR_W-1:0]    in_err;
   logic                       out_valid;
   logic [CTX_W-1:0]           out_ctx;
   logic [A_LENGTH-1:0]        out_A;
   logic signed [B_LENGTH-1:0] out_B;
   logic [N_LENGTH-1:0]        out_N;
   logic signed [7:0]          out_C;
   logic                       out_reset;

   modport master (
      output in_valid, in_ctx, in_err,
      input  in_ready, out_valid, out_ctx, out_A, out_B, out_N, out_C, out_reset
   );

   modport slave (
      input  in_valid, in_ctx, in_err,
      output in_ready, out_valid, out_ctx, out_A, out_B, out_N, out_C, out_reset
   );
endinterface

// File: rtl/context_stats_update.sv
// Per-context A/B/N statistics read-modify-write engine for the JPEG-LS regular-mode path.
// Define JPEGLS_BIAS_CORR_EN to add per-context C storage and the bias-correction update.
module context_stats_update #(
   parameter int unsigned NUM_CTX      = 365,
   parameter int unsigned CTX_W        = 9,
   parameter int unsigned N_LENGTH     = 7,
   parameter int unsigned A_LENGTH     = 16,
   parameter int unsigned B_LENGTH     = 8,
   parameter int unsigned ERR_W        = 9,
   parameter int unsigned RESET_THRESH = 64,
   parameter int unsigned A_INIT       = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  init_start,
   output logic                  busy,
   context_stats_update_if.slave bus
);
   localparam int unsigned      C_W      = 8;
   localparam logic [CTX_W-1:0] LAST_IDX = CTX_W'(NUM_CTX - 1);

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   state_e           state_q, state_d;
   logic [CTX_W-1:0] idx_q, idx_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;

   logic [A_LENGTH-1:0]        a_mem [NUM_CTX];
   logic signed [B_LENGTH-1:0] b_mem [NUM_CTX];
   logic [N_LENGTH-1:0]        n_mem [NUM_CTX];

   // Stage-1 registers are also the output registers
   logic                       out_valid_q;
   logic                       reset_q;
   logic [CTX_W-1:0]           ctx_q;
   logic [A_LENGTH-1:0]        a_q;
   logic signed [B_LENGTH-1:0] b_q;
   logic [N_LENGTH-1:0]        n_q;
   logic signed [ERR_W-1:0]    err_q;

   logic                       accept;
   logic                       fwd;
   logic [A_LENGTH-1:0]        rd_a, wb_a, a_sum;
   logic signed [B_LENGTH-1:0] rd_b, wb_b, b_sum, b_half;
   logic [N_LENGTH-1:0]        rd_n, wb_n;
   logic [ERR_W-1:0]           abs_err;

`ifdef JPEGLS_BIAS_CORR_EN
   localparam int unsigned CMP_W = ((B_LENGTH > N_LENGTH) ? B_LENGTH : N_LENGTH) + 2;
   localparam logic signed [C_W-1:0]   C_MIN  = 8'sh80;
   localparam logic signed [C_W-1:0]   C_MAX  = 8'sh7F;
   localparam logic signed [C_W-1:0]   C_ONE  = 8'sh01;
   localparam logic signed [CMP_W-1:0] ZERO_X = '0;
   localparam logic signed [CMP_W-1:0] ONE_X  = CMP_W'(1);

   logic signed [C_W-1:0]   c_mem [NUM_CTX];
   logic signed [C_W-1:0]   c_q, rd_c, wb_c;
   logic signed [CMP_W-1:0] b_x, n_x;
`endif

   // Init sweep / run control
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         ST_INIT: begin
            if (init_start) begin
               idx_d = '0;
            end else if (idx_q == LAST_IDX) begin
               state_d = ST_RUN;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + CTX_W'(1);
            end
         end
         ST_RUN: begin
            if (init_start) begin
               state_d = ST_INIT;
               idx_d   = '0;
            end
         end
         default: state_d = ST_INIT;
      endcase
      busy_d  = (state_d == ST_INIT);
      ready_d = (state_d == ST_RUN);
   end

   // S0: accept and read, bypassing the array when stage 1 is writing the same context
   always_comb begin
      accept = bus.in_valid && ready_q && !init_start;
      fwd    = out_valid_q && (bus.in_ctx == ctx_q);
      rd_a   = a_mem[bus.in_ctx];
      rd_b   = b_mem[bus.in_ctx];
      rd_n   = n_mem[bus.in_ctx];
`ifdef JPEGLS_BIAS_CORR_EN
      rd_c   = c_mem[bus.in_ctx];
`endif
      if (fwd) begin
         rd_a = wb_a;
         rd_b = wb_b;
         rd_n = wb_n;
`ifdef JPEGLS_BIAS_CORR_EN
         rd_c = wb_c;
`endif
      end
   end

   // S1: update arithmetic for the write-back
   always_comb begin
      abs_err = err_q[ERR_W-1] ? ERR_W'(-err_q) : ERR_W'(err_q);
      a_sum   = a_q + A_LENGTH'(abs_err);
      b_sum   = B_LENGTH'(b_q + err_q);
      if (reset_q) begin
         wb_a   = a_sum >> 1;
         b_half = b_sum >>> 1;
         wb_n   = (n_q >> 1) + N_LENGTH'(1);
      end else begin
         wb_a   = a_sum;
         b_half = b_sum;
         wb_n   = n_q + N_LENGTH'(1);
      end
`ifdef JPEGLS_BIAS_CORR_EN
      b_x  = CMP_W'(b_half);
      n_x  = CMP_W'(wb_n);
      wb_c = c_q;
      if (b_x <= -n_x) begin
         b_x = b_x + n_x;
         if (c_q != C_MIN) wb_c = c_q - C_ONE;
         if (b_x <= -n_x) b_x = ONE_X - n_x;
      end else if (b_x > ZERO_X) begin
         b_x = b_x - n_x;
         if (c_q != C_MAX) wb_c = c_q + C_ONE;
         if (b_x > ZERO_X) b_x = ZERO_X;
      end
      wb_b = B_LENGTH'(b_x);
`else
      wb_b = b_half;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         idx_q       <= '0;
         busy_q      <= 1'b1;
         ready_q     <= 1'b0;
         out_valid_q <= 1'b0;
         reset_q     <= 1'b0;
         ctx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         n_q         <= '0;
         err_q       <= '0;
`ifdef JPEGLS_BIAS_CORR_EN
         c_q         <= '0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
         out_valid_q <= accept;
         if (accept) begin
            ctx_q   <= bus.in_ctx;
            a_q     <= rd_a;
            b_q     <= rd_b;
            n_q     <= rd_n;
            err_q   <= bus.in_err;
            reset_q <= (rd_n == N_LENGTH'(RESET_THRESH));
`ifdef JPEGLS_BIAS_CORR_EN
            c_q     <= rd_c;
`endif
         end
      end
   end

   // Statistics array: init sweep or stage-1 write-back (never both in one cycle)
   always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
         a_mem[idx_q] <= A_LENGTH'(A_INIT);
         b_mem[idx_q] <= '0;
         n_mem[idx_q] <= N_LENGTH'(1);
`ifdef JPEGLS_BIAS_CORR_EN
         c_mem[idx_q] <= '0;
`endif
      end else if (out_valid_q) begin
         a_mem[ctx_q] <= wb_a;
         b_mem[ctx_q] <= wb_b;
         n_mem[ctx_q] <= wb_n;
`ifdef JPEGLS_BIAS_CORR_EN
         c_mem[ctx_q] <= wb_c;
`endif
      end
   end

   assign busy          = busy_q;
   assign bus.in_ready  = ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_ctx   = ctx_q;
   assign bus.out_A     = a_q;
   assign bus.out_B     = b_q;
   assign bus.out_N     = n_q;
   assign bus.out_reset = reset_q;
`ifdef JPEGLS_BIAS_CORR_EN
   assign bus.out_C     = c_q;
`else
   assign bus.out_C     = '0;
`endif

endmodule

// File: tb/tb_context_stats_update.sv
// Bench for context_stats_update: vector table, multi-cycle corner sequences and a randomized
// run scored against a per-context statistics model (follows JPEGLS_BIAS_CORR_EN when defined).
module tb_context_stats_update;
   localparam int NUM_CTX = 365;

   typedef struct { int a; int b; int n; int c; int r; } exp_t;
   typedef struct { int ctx; int err; int a; int b; int n; int c; int r; } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic init_start;
   logic busy;

   context_stats_update_if bus ();

   context_stats_update dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .init_start (init_start),
      .busy       (busy),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int mA [NUM_CTX];
   int mB [NUM_CTX];
   int mN [NUM_CTX];
   int mC [NUM_CTX];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic void model_init();
      for (int i = 0; i < NUM_CTX; i++) begin
         mA[i] = 4; mB[i] = 0; mN[i] = 1; mC[i] = 0;
      end
   endfunction

   function automatic int wrap_s8(input int x);
      int v = x & 255;
      return (v >= 128) ? v - 256 : v;
   endfunction

   function automatic int floor_half(input int x);
      return (x < 0 && (x % 2) != 0) ? (x - 1) / 2 : x / 2;
   endfunction

   // Returns pre-update statistics and applies the update in strict arrival order
   function automatic exp_t model_step(input int ctx, input int err);
      exp_t e;
      int a, b, n, c;
      e.a = mA[ctx]; e.b = mB[ctx]; e.n = mN[ctx]; e.c = mC[ctx];
      e.r = (mN[ctx] == 64) ? 1 : 0;
      a = (mA[ctx] + ((err < 0) ? -err : err)) & 65535;
      b = wrap_s8(mB[ctx] + err);
      if (e.r == 1) begin
         a = a / 2; b = floor_half(b); n = e.n / 2 + 1;
      end else begin
         n = e.n + 1;
      end
      c = e.c;
`ifdef JPEGLS_BIAS_CORR_EN
      if (b <= -n) begin
         b = b + n;
         if (c > -128) c = c - 1;
         if (b <= -n) b = 1 - n;
      end else if (b > 0) begin
         b = b - n;
         if (c < 127) c = c + 1;
         if (b > 0) b = 0;
      end
`endif
      mA[ctx] = a; mB[ctx] = b; mN[ctx] = n; mC[ctx] = c;
      return e;
   endfunction

   task automatic send(input int ctx, input int err, output exp_t e);
      check("in_ready before send", int'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_ctx   = 9'(ctx);
      bus.in_err   = 9'(err);
      e = model_step(ctx, err);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic check_out(input string tag, input int ctx, input exp_t e);
      check({tag, " out_valid"}, int'(bus.out_valid), 1);
      check({tag, " out_ctx"},   int'(bus.out_ctx), ctx);
      check({tag, " out_A"},     int'(bus.out_A), e.a);
      check({tag, " out_B"},     int'(bus.out_B), e.b);
      check({tag, " out_N"},     int'(bus.out_N), e.n);
      check({tag, " out_C"},     int'(bus.out_C), e.c);
      check({tag, " out_reset"}, int'(bus.out_reset), e.r);
   endtask

   task automatic wait_init(input string tag);
      int n = 0;
      while (busy && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, " busy cycles"}, n, NUM_CTX);
      check({tag, " in_ready after init"}, int'(bus.in_ready), 1);
      model_init();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: run still active at time %0t", $time);
      $fatal(1);
   end

   initial begin
      vec_t vt [9];
      exp_t e, last;
      int   ctx, err;

      vt[0] = '{5, 3, 4, 0, 1, 0, 0};
      vt[2] = '{7, -4, 4, 0, 1, 0, 0};
      vt[5] = '{1, 1, 4, 0, 1, 0, 0};
      vt[6] = '{2, 1, 4, 0, 1, 0, 0};
`ifdef JPEGLS_BIAS_CORR_EN
      vt[1] = '{5, 3, 7, 0, 2, 1, 0};
      vt[3] = '{7, -4, 8, -1, 2, -1, 0};
      vt[4] = '{7, -4, 12, -2, 3, -2, 0};
      vt[7] = '{1, 1, 5, -1, 2, 1, 0};
      vt[8] = '{2, 1, 5, -1, 2, 1, 0};
`else
      vt[1] = '{5, 3, 7, 3, 2, 0, 0};
      vt[3] = '{7, -4, 8, -4, 2, 0, 0};
      vt[4] = '{7, -4, 12, -8, 3, 0, 0};
      vt[7] = '{1, 1, 5, 1, 2, 0, 0};
      vt[8] = '{2, 1, 5, 1, 2, 0, 0};
`endif

      rst_n = 1'b0; init_start = 1'b0;
      bus.in_valid = 1'b0; bus.in_ctx = '0; bus.in_err = '0;
      model_init();
      repeat (3) @(posedge clk);
      #1;
      check("reset busy",      int'(busy), 1);
      check("reset in_ready",  int'(bus.in_ready), 0);
      check("reset out_valid", int'(bus.out_valid), 0);
      check("reset out_reset", int'(bus.out_reset), 0);
      check("reset out_ctx",   int'(bus.out_ctx), 0);
      check("reset out_A",     int'(bus.out_A), 0);
      check("reset out_B",     int'(bus.out_B), 0);
      check("reset out_N",     int'(bus.out_N), 0);
      check("reset out_C",     int'(bus.out_C), 0);
      rst_n = 1'b1;
      wait_init("power-up");

      // Spec vectors, back to back so each repeat context goes through the bypass
      for (int i = 0; i < 9; i++) begin
         send(vt[i].ctx, vt[i].err, e);
         check_out($sformatf("vec%0d", i), vt[i].ctx, '{vt[i].a, vt[i].b, vt[i].n, vt[i].c, vt[i].r});
      end
      last = e;

      // Halving at N == 64 on ctx 10: A reaches 100, B reaches -6 before the trigger
      send(10, -51, e); check_out("halv ramp", 10, e);
      send(10, 45, e);  check_out("halv ramp", 10, e);
      for (int i = 0; i < 61; i++) begin
         send(10, 0, e); check_out("halv ramp", 10, e);
      end
      send(10, 2, e); check_out("halv trig", 10, e);
      check("halv trig N",     int'(bus.out_N), 64);
      check("halv trig reset", int'(bus.out_reset), 1);
`ifndef JPEGLS_BIAS_CORR_EN
      check("halv trig A", int'(bus.out_A), 100);
      check("halv trig B", int'(bus.out_B), -6);
`endif
      send(10, 0, e); check_out("halv after", 10, e);
      check("halv after N",     int'(bus.out_N), 33);
      check("halv after reset", int'(bus.out_reset), 0);
`ifndef JPEGLS_BIAS_CORR_EN
      check("halv after A", int'(bus.out_A), 51);
      check("halv after B", int'(bus.out_B), -2);
`endif
      last = e;

      // Randomized traffic with idle gaps; a small context pool keeps the bypass busy
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
            check("idle out_valid", int'(bus.out_valid), 0);
            check("idle out_A hold", int'(bus.out_A), last.a);
            check("idle out_N hold", int'(bus.out_N), last.n);
         end else begin
            ctx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NUM_CTX - 1))
                                              : int'($urandom_range(0, 5));
            err = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 511)) - 256
                                              : int'($urandom_range(0, 40)) - 20;
            send(ctx, err, e);
            check_out("rand", ctx, e);
            last = e;
         end
      end

      // init_start while a sample sits in stage 1 and another is offered
      send(20, 5, e);
      check_out("init s1", 20, e);
      bus.in_valid = 1'b1; bus.in_ctx = 9'd21; bus.in_err = 9'd7; init_start = 1'b1;
      @(posedge clk); #1;
      init_start = 1'b0; bus.in_valid = 1'b0;
      check("init dropped sample", int'(bus.out_valid), 0);
      check("init busy",           int'(busy), 1);
      check("init in_ready",       int'(bus.in_ready), 0);
      wait_init("init_start");
      send(7, 0, e);
      check_out("post-init ctx7", 7, '{4, 0, 1, 0, 0});

      // Asynchronous reset in the middle of a valid output
      send(3, 9, e);
      #3 rst_n = 1'b0;
      #1;
      check("async rst out_valid", int'(bus.out_valid), 0);
      check("async rst busy",      int'(busy), 1);
      check("async rst in_ready",  int'(bus.in_ready), 0);
      check("async rst out_A",     int'(bus.out_A), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_init("mid reset");
      send(3, -4, e); check_out("post-reset ctx3", 3, '{4, 0, 1, 0, 0});
      send(3, 0, e);  check_out("post-reset ctx3 next", 3, e);
`ifdef JPEGLS_BIAS_CORR_EN
      check("bias C after -4", int'(bus.out_C), -1);
      check("bias B after -4", int'(bus.out_B), -1);
`else
      check("ctx3 B after -4", int'(bus.out_B), -4);
      check("ctx3 C tied",     int'(bus.out_C), 0);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
